tx_packeting: RTL and testbench

Transmit-side packetizer of the DoCE transport layer, the counterpart of the receive depacketizer. Accepts a per-packet header descriptor and a payload AXI-stream from the transport engine, emits one 128-bit header beat followed by the payload beats toward the router, and enforces the declared payload length. The router-facing output is a registered stage, so outputs are timing-clean.

---
 rtl/doce_pkg.sv | 35 +++
 rtl/axis_reg_slice.sv | 48 ++++
 rtl/tx_packeting.sv | 181 ++++++++++++++++++
 tb/tb_tx_packeting.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doce_pkg.sv
// Shared DoCE transport definitions: header field layout, magic tag and packetizer states.
package doce_pkg;

  localparam int MAGIC_LSB = 112;
  localparam int DST_LSB   = 96;
  localparam int SRC_LSB   = 80;
  localparam int LEN_LSB   = 72;
  localparam int SEQ_LSB   = 64;

  localparam logic [15:0] DOCE_HDR_MAGIC = 16'hD0CE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } tx_state_e;

  // Lower 64 bits of the header beat are reserved and sent as zero.
  function automatic logic [127:0] build_hdr(input logic [15:0] magic,
                                             input logic [15:0] dst,
                                             input logic [15:0] src,
                                             input logic [7:0]  len,
                                             input logic [7:0]  seq);
    logic [127:0] h;
    h = 128'h0;
    h[MAGIC_LSB +: 16] = magic;
    h[DST_LSB   +: 16] = dst;
    h[SRC_LSB   +: 16] = src;
    h[LEN_LSB   +: 8]  = len;
    h[SEQ_LSB   +: 8]  = seq;
    return h;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-stream output register; the producer writes only when load_o is high.
module axis_reg_slice #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic [KEEP_W-1:0] tkeep_i,
  input  logic              tlast_i,
  input  logic              ready_i,
  output logic              load_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic [KEEP_W-1:0] tkeep_o,
  output logic              tlast_o
);

  logic              valid_q;
  logic [DATA_W-1:0] tdata_q;
  logic [KEEP_W-1:0] tkeep_q;
  logic              tlast_q;

  assign load_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign tdata_o = tdata_q;
  assign tkeep_o = tkeep_q;
  assign tlast_o = tlast_q;

  // Register advances only when empty or being drained, so a stalled beat stays stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
    end else if (load_o) begin
      valid_q <= wr_i;
      if (wr_i) begin
        tdata_q <= tdata_i;
        tkeep_q <= tkeep_i;
        tlast_q <= tlast_i;
      end
    end
  end

endmodule

// File: rtl/tx_packeting.sv
// DoCE transmit packetizer: header beat then payload beats into a registered output stage.
// Define TX_PACKETING_LEN_CHECK_EN to enforce the declared payload length (forced tlast, drain, io_len_err).
module tx_packeting
  import doce_pkg::*;
#(
  parameter logic [15:0] SRC_NODE_ID = 16'h0000,
  parameter logic [15:0] HDR_MAGIC   = DOCE_HDR_MAGIC
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_pkt_hdr_valid,
  output logic         io_pkt_hdr_ready,
  input  logic [15:0]  io_pkt_hdr_bits_dst,
  input  logic [7:0]   io_pkt_hdr_bits_len,
  input  logic         io_axis_str_from_trans_valid,
  output logic         io_axis_str_from_trans_ready,
  input  logic [127:0] io_axis_str_from_trans_bits_tdata,
  input  logic [3:0]   io_axis_str_from_trans_bits_tkeep,
  input  logic         io_axis_str_from_trans_bits_tlast,
  output logic         io_axi_str_to_router_valid,
  input  logic         io_axi_str_to_router_ready,
  output logic [127:0] io_axi_str_to_router_bits_tdata,
  output logic [3:0]   io_axi_str_to_router_bits_tkeep,
  output logic         io_axi_str_to_router_bits_tlast,
  output logic         io_len_err
);

  tx_state_e    state_q, state_d;
  logic [7:0]   seq_q, seq_d;
  logic         load_s;
  logic         wr_s;
  logic [127:0] out_data_s;
  logic [3:0]   out_keep_s;
  logic         out_last_s;
  logic         hdr_ready_s;
  logic         axis_ready_s;

`ifdef TX_PACKETING_LEN_CHECK_EN
  logic [7:0]   len_q, len_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         len_err_q, len_err_d;
  logic         last_exp_s;

  assign last_exp_s = (cnt_q == (len_q - 8'd1));
  assign io_len_err = len_err_q;
`else
  assign io_len_err = 1'b0;
`endif

  assign io_pkt_hdr_ready             = hdr_ready_s;
  assign io_axis_str_from_trans_ready = axis_ready_s;

  // Next-state, handshake readies and output-register write data.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    hdr_ready_s  = 1'b0;
    axis_ready_s = 1'b0;
    wr_s         = 1'b0;
    out_data_s   = 128'h0;
    out_keep_s   = 4'h0;
    out_last_s   = 1'b0;
`ifdef TX_PACKETING_LEN_CHECK_EN
    len_d        = len_q;
    cnt_d        = cnt_q;
    len_err_d    = len_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        hdr_ready_s = load_s;
        if (io_pkt_hdr_valid && load_s) begin
          wr_s       = 1'b1;
          out_data_s = build_hdr(HDR_MAGIC, io_pkt_hdr_bits_dst, SRC_NODE_ID,
                                 io_pkt_hdr_bits_len, seq_q);
          out_keep_s = 4'hF;
          out_last_s = (io_pkt_hdr_bits_len == 8'd0);
          seq_d      = seq_q + 8'd1;
`ifdef TX_PACKETING_LEN_CHECK_EN
          len_d      = io_pkt_hdr_bits_len;
          cnt_d      = 8'd0;
`endif
          if (io_pkt_hdr_bits_len == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        axis_ready_s = load_s;
        if (io_axis_str_from_trans_valid && load_s) begin
          wr_s       = 1'b1;
          out_data_s = io_axis_str_from_trans_bits_tdata;
          out_keep_s = io_axis_str_from_trans_bits_tkeep;
`ifdef TX_PACKETING_LEN_CHECK_EN
          cnt_d      = cnt_q + 8'd1;
          out_last_s = last_exp_s || io_axis_str_from_trans_bits_tlast;
          if (last_exp_s) begin
            if (io_axis_str_from_trans_bits_tlast) begin
              state_d = ST_IDLE;
            end else begin
              len_err_d = 1'b1;
              state_d   = ST_DRAIN;
            end
          end else if (io_axis_str_from_trans_bits_tlast) begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
`else
          out_last_s = io_axis_str_from_trans_bits_tlast;
          if (io_axis_str_from_trans_bits_tlast) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
`endif
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
`ifdef TX_PACKETING_LEN_CHECK_EN
      // Surplus beats are swallowed without touching the output register.
      ST_DRAIN: begin
        axis_ready_s = 1'b1;
        if (io_axis_str_from_trans_valid && io_axis_str_from_trans_bits_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and packet bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      seq_q     <= 8'd0;
`ifdef TX_PACKETING_LEN_CHECK_EN
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      len_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
`ifdef TX_PACKETING_LEN_CHECK_EN
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
`endif
    end
  end

  axis_reg_slice #(
    .DATA_W (128),
    .KEEP_W (4)
  ) u_out_reg (
    .clock   (clock),
    .reset   (reset),
    .wr_i    (wr_s),
    .tdata_i (out_data_s),
    .tkeep_i (out_keep_s),
    .tlast_i (out_last_s),
    .ready_i (io_axi_str_to_router_ready),
    .load_o  (load_s),
    .valid_o (io_axi_str_to_router_valid),
    .tdata_o (io_axi_str_to_router_bits_tdata),
    .tkeep_o (io_axi_str_to_router_bits_tkeep),
    .tlast_o (io_axi_str_to_router_bits_tlast)
  );

endmodule

// File: tb/tb_tx_packeting.sv
// Scoreboard bench for tx_packeting; expectations follow TX_PACKETING_LEN_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_tx_packeting;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         hdr_valid = 1'b0;
  logic         hdr_ready;
  logic [15:0]  hdr_dst = 16'h0;
  logic [7:0]   hdr_len = 8'h0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = 128'h0;
  logic [3:0]   in_keep = 4'h0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         rtr_ready;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic         out_last;
  logic         len_err;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    seq_m  = 0;
  logic  err_m  = 1'b0;
  bit    rdy_toggle = 1'b0;
  logic  rdy_level  = 1'b1;

  tx_packeting dut (
    .clock                             (clock),
    .reset                             (reset),
    .io_pkt_hdr_valid                  (hdr_valid),
    .io_pkt_hdr_ready                  (hdr_ready),
    .io_pkt_hdr_bits_dst               (hdr_dst),
    .io_pkt_hdr_bits_len               (hdr_len),
    .io_axis_str_from_trans_valid      (in_valid),
    .io_axis_str_from_trans_ready      (in_ready),
    .io_axis_str_from_trans_bits_tdata (in_data),
    .io_axis_str_from_trans_bits_tkeep (in_keep),
    .io_axis_str_from_trans_bits_tlast (in_last),
    .io_axi_str_to_router_valid        (out_valid),
    .io_axi_str_to_router_ready        (rtr_ready),
    .io_axi_str_to_router_bits_tdata   (out_data),
    .io_axi_str_to_router_bits_tkeep   (out_keep),
    .io_axi_str_to_router_bits_tlast   (out_last),
    .io_len_err                        (len_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [132:0] got, input logic [132:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Router ready driver: either a held level or a 1/0 toggle per cycle.
  initial begin
    rtr_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rdy_toggle) rtr_ready = ~rtr_ready;
      else rtr_ready = rdy_level;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stability during stalls.
  initial begin
    beat_t cur, held_b, e;
    bit    held;
    held = 1'b0;
    forever begin
      @(negedge clock);
      cur = '{data: out_data, keep: out_keep, last: out_last};
      if (reset) begin
        held = 1'b0;
      end else if (out_valid) begin
        if (held) chk("hold_stable", 133'(cur), 133'(held_b));
        if (rtr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", cur);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", 133'(cur), 133'(e));
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_b = cur;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send_hdr(input logic [15:0] dst, input logic [7:0] len);
    bit ok;
    beat_t h;
    ok = 1'b0;
    hdr_valid = 1'b1;
    hdr_dst   = dst;
    hdr_len   = len;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (hdr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clock);
      #1;
      h.data = {16'hD0CE, dst, 16'h0000, len, 8'(seq_m), 64'h0};
      h.keep = 4'hF;
      h.last = (len == 8'd0);
      exp_q.push_back(h);
      seq_m = (seq_m + 1) % 256;
    end else begin
      checks++;
      errors++;
      $display("FAIL hdr_timeout: got no hdr_ready expected handshake");
    end
    hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clock);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no payload ready expected handshake");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends one descriptor plus nb payload beats (tlast on the final one) and predicts the output.
  task automatic send_pkt(input logic [15:0] dst, input int len, input int nb);
    beat_t b;
    bit    fwd;
    logic  l;
    fwd = 1'b1;
    send_hdr(dst, 8'(len));
    for (int i = 0; i < nb; i++) begin
      l      = (i == nb - 1);
      b.data = {dst, 16'hBEA7, 32'(i), 32'hC0DE_0000 | 32'(len), 32'(seq_m)};
      b.keep = l ? 4'h3 : 4'hF;
      send_beat(b.data, b.keep, l);
`ifdef TX_PACKETING_LEN_CHECK_EN
      if (fwd) begin
        b.last = l || (i == len - 1);
        exp_q.push_back(b);
        if (i == len - 1) begin
          if (!l) err_m = 1'b1;
          fwd = 1'b0;
        end else if (l) begin
          err_m = 1'b1;
        end
      end
`else
      b.last = l;
      exp_q.push_back(b);
`endif
    end
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    chk({nm, "_len_err"}, 133'(len_err), 133'(err_m));
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 133'(out_valid), 133'(0));
    chk("rst_data", {out_data, out_keep, out_last}, 133'(0));
    chk("rst_len_err", 133'(len_err), 133'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_hdr_ready", 133'(hdr_ready), 133'(1));
    chk("idle_in_ready", 133'(in_ready), 133'(0));
    @(posedge clock);
    #1;

    // Basic packet: header tdata[127:64] = D0CE_0005_0000_0200.
    send_pkt(16'h0005, 2, 2);
    wait_drain("len2");

    // Header-only packet: payload ready must stay low afterwards.
    send_pkt(16'h0009, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("len0_in_ready", 133'(in_ready), 133'(0));
    end
    wait_drain("len0");

    send_pkt(16'h0011, 3, 2);
    wait_drain("short");

    send_pkt(16'h0022, 2, 4);
    send_pkt(16'h0033, 1, 1);
    wait_drain("long");

    rdy_toggle = 1'b1;
    send_pkt(16'h0044, 4, 4);
    wait_drain("toggle");
    rdy_toggle = 1'b0;
    rdy_level  = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    for (int p = 0; p < 256; p++) send_pkt(16'(p), 1, 1);
    wait_drain("b2b");

    // Reset while a header is stalled in the output register.
    rdy_level = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    send_hdr(16'h0055, 8'd4);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_valid", 133'(out_valid), 133'(0));
    chk("midrst_last", 133'(out_last), 133'(0));
    chk("midrst_len_err", 133'(len_err), 133'(0));
    exp_q.delete();
    seq_m = 0;
    err_m = 1'b0;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    rdy_level = 1'b1;
    @(posedge clock);
    #1;
    send_pkt(16'h0066, 0, 0);
    wait_drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
